// File: rtl/axi4l_to_wb_bridge.sv
// AXI4-Lite slave to pipelined Wishbone master bridge, one transaction at a time.
// Optional Wishbone cycle timeout is built when AXI4L2WB_TIMEOUT_EN is defined.
module axi4l_to_wb_bridge #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                    CLK,
    input  logic                    RSTN,
    input  logic [ADDR_WIDTH-1:0]   s_awaddr,
    input  logic                    s_awvalid,
    output logic                    s_awready,
    input  logic [DATA_WIDTH-1:0]   s_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_wstrb,
    input  logic                    s_wvalid,
    output logic                    s_wready,
    output logic [1:0]              s_bresp,
    output logic                    s_bvalid,
    input  logic                    s_bready,
    input  logic [ADDR_WIDTH-1:0]   s_araddr,
    input  logic                    s_arvalid,
    output logic                    s_arready,
    output logic [DATA_WIDTH-1:0]   s_rdata,
    output logic [1:0]              s_rresp,
    output logic                    s_rvalid,
    input  logic                    s_rready,
    output logic                    wb_cyc,
    output logic                    wb_stb,
    output logic                    wb_we,
    output logic [ADDR_WIDTH-1:0]   wb_adr,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    output logic [DATA_WIDTH/8-1:0] wb_sel,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    input  logic                    wb_ack,
    input  logic                    wb_err,
    input  logic                    wb_stall
);
    localparam int unsigned StrbW = DATA_WIDTH / 8;

    typedef enum logic [2:0] {StIdle, StWbReq, StWbWait, StBResp, StRResp} state_e;

    state_e                state_q;
    logic                  aw_held_q, w_held_q, ar_held_q, last_was_write_q;
    logic [ADDR_WIDTH-1:0] aw_addr_q, ar_addr_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [StrbW-1:0]      w_strb_q;

    logic idle, aw_in, w_in, ar_in, aw_ok, w_ok, ar_ok;
    logic write_pend, read_pend, grant_write, grant_read;
    logic timeout_hit, wb_end, resp_err;

    assign idle      = (state_q == StIdle);
    assign s_awready = RSTN & idle & ~aw_held_q;
    assign s_wready  = RSTN & idle & ~w_held_q;
    assign s_arready = RSTN & idle & ~ar_held_q;

    assign aw_in = s_awvalid & s_awready;
    assign w_in  = s_wvalid & s_wready;
    assign ar_in = s_arvalid & s_arready;

    // Requests completing their handshake this cycle can be granted on the same edge.
    assign aw_ok = aw_held_q | aw_in;
    assign w_ok  = w_held_q | w_in;
    assign ar_ok = ar_held_q | ar_in;

    assign write_pend  = idle & aw_ok & w_ok;
    assign read_pend   = idle & ar_ok;
    assign grant_write = write_pend & (~read_pend | ~last_was_write_q);
    assign grant_read  = read_pend & ~grant_write;

    assign wb_end   = wb_cyc & (wb_ack | wb_err | timeout_hit);
    assign resp_err = wb_err | (timeout_hit & ~wb_ack);

`ifdef AXI4L2WB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] tmo_cnt_q;

    always_ff @(posedge CLK) begin
        if (!RSTN || !wb_cyc) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end

    assign timeout_hit = wb_cyc && (tmo_cnt_q == CntW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;

    // TIMEOUT_CYCLES only matters when the timeout counter is built.
    if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
    end
`endif

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q          <= StIdle;
            aw_held_q        <= 1'b0;
            w_held_q         <= 1'b0;
            ar_held_q        <= 1'b0;
            last_was_write_q <= 1'b0;
            aw_addr_q        <= '0;
            ar_addr_q        <= '0;
            w_data_q         <= '0;
            w_strb_q         <= '0;
            wb_cyc           <= 1'b0;
            wb_stb           <= 1'b0;
            wb_we            <= 1'b0;
            wb_adr           <= '0;
            wb_dat_o         <= '0;
            wb_sel           <= '0;
            s_bvalid         <= 1'b0;
            s_bresp          <= 2'b00;
            s_rvalid         <= 1'b0;
            s_rresp          <= 2'b00;
            s_rdata          <= '0;
        end else begin
            if (aw_in) aw_addr_q <= s_awaddr;
            if (w_in) begin
                w_data_q <= s_wdata;
                w_strb_q <= s_wstrb;
            end
            if (ar_in) ar_addr_q <= s_araddr;

            if (grant_write) begin
                aw_held_q <= 1'b0;
                w_held_q  <= 1'b0;
            end else begin
                if (aw_in) aw_held_q <= 1'b1;
                if (w_in)  w_held_q  <= 1'b1;
            end
            if (grant_read) begin
                ar_held_q <= 1'b0;
            end else if (ar_in) begin
                ar_held_q <= 1'b1;
            end

            unique case (state_q)
                StIdle: begin
                    if (grant_write) begin
                        wb_adr           <= aw_held_q ? aw_addr_q : s_awaddr;
                        wb_dat_o         <= w_held_q ? w_data_q : s_wdata;
                        wb_sel           <= w_held_q ? w_strb_q : s_wstrb;
                        wb_we            <= 1'b1;
                        wb_cyc           <= 1'b1;
                        wb_stb           <= 1'b1;
                        last_was_write_q <= 1'b1;
                        state_q          <= StWbReq;
                    end else if (grant_read) begin
                        wb_adr           <= ar_held_q ? ar_addr_q : s_araddr;
                        wb_dat_o         <= '0;
                        wb_sel           <= '1;
                        wb_we            <= 1'b0;
                        wb_cyc           <= 1'b1;
                        wb_stb           <= 1'b1;
                        last_was_write_q <= 1'b0;
                        state_q          <= StWbReq;
                    end
                end
                StWbReq, StWbWait: begin
                    if (wb_end) begin
                        wb_cyc <= 1'b0;
                        wb_stb <= 1'b0;
                        wb_we  <= 1'b0;
                        if (wb_we) begin
                            s_bresp  <= resp_err ? 2'b10 : 2'b00;
                            s_bvalid <= 1'b1;
                            state_q  <= StBResp;
                        end else begin
                            s_rresp  <= resp_err ? 2'b10 : 2'b00;
                            s_rdata  <= resp_err ? '0 : wb_dat_i;
                            s_rvalid <= 1'b1;
                            state_q  <= StRResp;
                        end
                    end else if (state_q == StWbReq && !wb_stall) begin
                        wb_stb  <= 1'b0;
                        state_q <= StWbWait;
                    end
                end
                StBResp: begin
                    if (s_bready) begin
                        s_bvalid <= 1'b0;
                        state_q  <= StIdle;
                    end
                end
                StRResp: begin
                    if (s_rready) begin
                        s_rvalid <= 1'b0;
                        state_q  <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4l_to_wb_bridge.sv
// Directed self-checking bench for axi4l_to_wb_bridge.
// Timeout scenario is compiled in when AXI4L2WB_TIMEOUT_EN is defined.
module tb_axi4l_to_wb_bridge;
    logic        CLK = 1'b0;
    logic        RSTN;
    logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
    logic [3:0]  s_wstrb;
    logic        s_awvalid, s_awready, s_wvalid, s_wready;
    logic [1:0]  s_bresp, s_rresp;
    logic        s_bvalid, s_bready, s_arvalid, s_arready, s_rvalid, s_rready;
    logic        wb_cyc, wb_stb, wb_we, wb_ack, wb_err, wb_stall;
    logic [31:0] wb_adr, wb_dat_o, wb_dat_i;
    logic [3:0]  wb_sel;

    int vectors = 0;
    int miscompares = 0;

    always #5 CLK = ~CLK;

    axi4l_to_wb_bridge #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .s_awaddr  (s_awaddr),
        .s_awvalid (s_awvalid),
        .s_awready (s_awready),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .s_wvalid  (s_wvalid),
        .s_wready  (s_wready),
        .s_bresp   (s_bresp),
        .s_bvalid  (s_bvalid),
        .s_bready  (s_bready),
        .s_araddr  (s_araddr),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_rdata   (s_rdata),
        .s_rresp   (s_rresp),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready),
        .wb_cyc    (wb_cyc),
        .wb_stb    (wb_stb),
        .wb_we     (wb_we),
        .wb_adr    (wb_adr),
        .wb_dat_o  (wb_dat_o),
        .wb_sel    (wb_sel),
        .wb_dat_i  (wb_dat_i),
        .wb_ack    (wb_ack),
        .wb_err    (wb_err),
        .wb_stall  (wb_stall)
    );

    // Each cycle: drive and sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RSTN = 1'b0;
        s_awaddr = '0; s_awvalid = 0; s_wdata = '0; s_wstrb = '0; s_wvalid = 0;
        s_bready = 0; s_araddr = '0; s_arvalid = 0; s_rready = 0;
        wb_dat_i = '0; wb_ack = 0; wb_err = 0; wb_stall = 0;
        tick(); tick();
        vectors++;
        if ({s_awready, s_wready, s_arready} !== 3'b000) begin
            miscompares++;
            $display("FAIL rst_ready: got %b want 000", {s_awready, s_wready, s_arready});
        end
        vectors++;
        if ({wb_cyc, wb_stb, wb_we, s_bvalid, s_rvalid} !== 5'b0) begin
            miscompares++;
            $display("FAIL rst_ctrl: got %b want 00000",
                     {wb_cyc, wb_stb, wb_we, s_bvalid, s_rvalid});
        end
        vectors++;
        if ({wb_adr, wb_dat_o, wb_sel, s_rdata, s_bresp, s_rresp} !== 104'h0) begin
            miscompares++;
            $display("FAIL rst_data: got %h want 0",
                     {wb_adr, wb_dat_o, wb_sel, s_rdata, s_bresp, s_rresp});
        end
        RSTN = 1'b1;
        #1;
        vectors++;
        if ({s_awready, s_wready, s_arready} !== 3'b111) begin
            miscompares++;
            $display("FAIL rel_ready: got %b want 111", {s_awready, s_wready, s_arready});
        end
    endtask

    task automatic test_write_stall();
        int stb_cnt = 0;
        s_awaddr = 32'h10; s_awvalid = 1; s_wdata = 32'hDEADBEEF; s_wstrb = 4'hF; s_wvalid = 1;
        wb_stall = 1;
        tick();
        s_awvalid = 0; s_wvalid = 0;
        vectors++;
        if ({wb_adr, wb_sel, wb_dat_o, wb_we} !== {32'h10, 4'hF, 32'hDEADBEEF, 1'b1}) begin
            miscompares++;
            $display("FAIL ws_req: got %h %h %h %b want 10 f deadbeef 1",
                     wb_adr, wb_sel, wb_dat_o, wb_we);
        end
        vectors++;
        if (s_awready !== 1'b0) begin
            miscompares++;
            $display("FAIL ws_busy_ready: got %b want 0", s_awready);
        end
        for (int k = 1; k <= 5; k++) begin
            wb_stall = (k <= 3);
            wb_ack   = (k == 5);
            if (wb_stb) stb_cnt++;
            tick();
        end
        wb_ack = 0; wb_stall = 0;
        vectors++;
        if (stb_cnt !== 4) begin
            miscompares++;
            $display("FAIL ws_stb_len: got %0d want 4", stb_cnt);
        end
        vectors++;
        if ({s_bvalid, s_bresp, wb_cyc, wb_stb} !== 5'b1_00_0_0) begin
            miscompares++;
            $display("FAIL ws_bresp: got %b want 10000", {s_bvalid, s_bresp, wb_cyc, wb_stb});
        end
        s_bready = 1;
        tick();
        s_bready = 0;
        vectors++;
        if ({s_bvalid, s_awready} !== 2'b01) begin
            miscompares++;
            $display("FAIL ws_done: got %b want 01", {s_bvalid, s_awready});
        end
    endtask

    task automatic test_split_write();
        s_wdata = 32'h12345678; s_wstrb = 4'h3; s_wvalid = 1;
        tick();
        s_wvalid = 0;
        vectors++;
        if ({s_wready, wb_cyc} !== 2'b00) begin
            miscompares++;
            $display("FAIL sw_wait1: got %b want 00", {s_wready, wb_cyc});
        end
        tick();
        vectors++;
        if (wb_cyc !== 1'b0) begin
            miscompares++;
            $display("FAIL sw_wait2: got %b want 0", wb_cyc);
        end
        s_awaddr = 32'h20; s_awvalid = 1;
        tick();
        s_awvalid = 0;
        vectors++;
        if ({wb_cyc, wb_adr, wb_sel, wb_dat_o} !== {1'b1, 32'h20, 4'h3, 32'h12345678}) begin
            miscompares++;
            $display("FAIL sw_req: got %b %h %h %h want 1 20 3 12345678",
                     wb_cyc, wb_adr, wb_sel, wb_dat_o);
        end
        wb_ack = 1;
        tick();
        wb_ack = 0;
        vectors++;
        if ({s_bvalid, s_bresp} !== 3'b100) begin
            miscompares++;
            $display("FAIL sw_bresp: got %b want 100", {s_bvalid, s_bresp});
        end
        s_bready = 1;
        tick();
        s_bready = 0;
    endtask

    task automatic test_read_err();
        s_araddr = 32'h40; s_arvalid = 1;
        tick();
        s_arvalid = 0;
        vectors++;
        if ({wb_cyc, wb_we, wb_adr, wb_sel, wb_dat_o} !== {2'b10, 32'h40, 4'hF, 32'h0}) begin
            miscompares++;
            $display("FAIL re_req: got %b %b %h %h %h want 1 0 40 f 0",
                     wb_cyc, wb_we, wb_adr, wb_sel, wb_dat_o);
        end
        wb_err = 1; wb_dat_i = 32'h55555555;
        tick();
        wb_err = 0;
        vectors++;
        if ({s_rvalid, s_rresp, s_rdata} !== {3'b110, 32'h0}) begin
            miscompares++;
            $display("FAIL re_err: got %b %b %h want 1 10 0", s_rvalid, s_rresp, s_rdata);
        end
        s_rready = 1;
        tick();
        s_rready = 0;
        s_araddr = 32'h44; s_arvalid = 1;
        tick();
        s_arvalid = 0;
        wb_ack = 1; wb_dat_i = 32'hCAFEF00D;
        tick();
        wb_ack = 0; wb_dat_i = 32'h0;
        vectors++;
        if ({s_rvalid, s_rresp, s_rdata} !== {3'b100, 32'hCAFEF00D}) begin
            miscompares++;
            $display("FAIL re_ok: got %b %b %h want 1 00 cafef00d", s_rvalid, s_rresp, s_rdata);
        end
        tick();
        vectors++;
        if ({s_rvalid, s_rdata} !== {1'b1, 32'hCAFEF00D}) begin
            miscompares++;
            $display("FAIL re_hold: got %b %h want 1 cafef00d", s_rvalid, s_rdata);
        end
        s_rready = 1;
        tick();
        s_rready = 0;
    endtask

    task automatic test_round_robin();
        // Round 1: both pending with write-favoured flag -> write first.
        s_awaddr = 32'h100; s_wdata = 32'hA1; s_wstrb = 4'hF; s_araddr = 32'h200;
        s_awvalid = 1; s_wvalid = 1; s_arvalid = 1;
        tick();
        s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
        vectors++;
        if ({wb_we, wb_adr} !== {1'b1, 32'h100}) begin
            miscompares++;
            $display("FAIL rr1_first: got %b %h want 1 100", wb_we, wb_adr);
        end
        wb_err = 1;
        tick();
        wb_err = 0;
        for (int k = 0; k < 5; k++) begin
            vectors++;
            if ({s_bvalid, s_bresp, wb_cyc} !== 4'b1_10_0) begin
                miscompares++;
                $display("FAIL rr_bp%0d: got %b want 1100", k, {s_bvalid, s_bresp, wb_cyc});
            end
            tick();
        end
        s_bready = 1;
        tick();
        s_bready = 0;
        tick();
        vectors++;
        if ({wb_cyc, wb_we, wb_adr} !== {2'b10, 32'h200}) begin
            miscompares++;
            $display("FAIL rr1_second: got %b %b %h want 1 0 200", wb_cyc, wb_we, wb_adr);
        end
        wb_ack = 1; wb_dat_i = 32'h11;
        tick();
        wb_ack = 0;
        s_rready = 1;
        tick();
        s_rready = 0;
        // Lone write leaves the flag pointing at the read side.
        s_awaddr = 32'h300; s_awvalid = 1; s_wvalid = 1;
        tick();
        s_awvalid = 0; s_wvalid = 0;
        wb_ack = 1;
        tick();
        wb_ack = 0;
        s_bready = 1;
        tick();
        s_bready = 0;
        // Round 2: both pending, write served last -> read first.
        s_awaddr = 32'h400; s_araddr = 32'h500;
        s_awvalid = 1; s_wvalid = 1; s_arvalid = 1;
        tick();
        s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
        vectors++;
        if ({wb_we, wb_adr} !== {1'b0, 32'h500}) begin
            miscompares++;
            $display("FAIL rr2_first: got %b %h want 0 500", wb_we, wb_adr);
        end
        wb_ack = 1; wb_dat_i = 32'h22;
        tick();
        wb_ack = 0;
        vectors++;
        if ({s_rvalid, s_rdata} !== {1'b1, 32'h22}) begin
            miscompares++;
            $display("FAIL rr2_rdata: got %b %h want 1 22", s_rvalid, s_rdata);
        end
        s_rready = 1;
        tick();
        s_rready = 0;
        vectors++;
        if ({s_awready, s_wready, s_arready} !== 3'b001) begin
            miscompares++;
            $display("FAIL rr2_held: got %b want 001", {s_awready, s_wready, s_arready});
        end
        tick();
        vectors++;
        if ({wb_cyc, wb_we, wb_adr} !== {2'b11, 32'h400}) begin
            miscompares++;
            $display("FAIL rr2_second: got %b %b %h want 1 1 400", wb_cyc, wb_we, wb_adr);
        end
        wb_ack = 1;
        tick();
        wb_ack = 0;
        s_bready = 1;
        tick();
        s_bready = 0;
    endtask

`ifdef AXI4L2WB_TIMEOUT_EN
    task automatic test_timeout();
        s_awaddr = 32'h600; s_awvalid = 1; s_wvalid = 1;
        tick();
        s_awvalid = 0; s_wvalid = 0;
        for (int k = 1; k < 8; k++) tick();
        vectors++;
        if (wb_cyc !== 1'b1) begin
            miscompares++;
            $display("FAIL to_cyc8: got %b want 1", wb_cyc);
        end
        tick();
        vectors++;
        if ({wb_cyc, s_bvalid, s_bresp} !== 4'b0_1_10) begin
            miscompares++;
            $display("FAIL to_resp: got %b want 0110", {wb_cyc, s_bvalid, s_bresp});
        end
        s_bready = 1;
        tick();
        s_bready = 0;
    endtask
`endif

    task automatic test_reset_mid();
        wb_stall = 1;
        s_araddr = 32'h700; s_arvalid = 1;
        tick();
        s_arvalid = 0;
        vectors++;
        if ({wb_cyc, wb_stb} !== 2'b11) begin
            miscompares++;
            $display("FAIL rm_active: got %b want 11", {wb_cyc, wb_stb});
        end
        RSTN = 0;
        tick();
        vectors++;
        if ({wb_cyc, wb_stb, s_rvalid, s_bvalid} !== 4'b0000) begin
            miscompares++;
            $display("FAIL rm_drop: got %b want 0000", {wb_cyc, wb_stb, s_rvalid, s_bvalid});
        end
        RSTN = 1; wb_stall = 0; wb_ack = 1;
        #1;
        vectors++;
        if ({s_awready, s_wready, s_arready} !== 3'b111) begin
            miscompares++;
            $display("FAIL rm_ready: got %b want 111", {s_awready, s_wready, s_arready});
        end
        tick(); tick();
        wb_ack = 0;
        vectors++;
        if ({wb_cyc, s_rvalid, s_bvalid} !== 3'b000) begin
            miscompares++;
            $display("FAIL rm_discard: got %b want 000", {wb_cyc, s_rvalid, s_bvalid});
        end
    endtask

    initial begin
        test_reset();
        test_write_stall();
        test_split_write();
        test_read_err();
        test_round_robin();
`ifdef AXI4L2WB_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
